// File: rtl/ov7670_sccb_sender.sv
// OV7670 configuration sender: walks the register-list ROM and writes every
// {reg, value} entry to the camera as a 3-phase SCCB write
// (device address, register, value), with a settle delay after COM7 reset.
module ov7670_sccb_sender #(
    parameter int         CLK_DIV    = 125,
    parameter logic [7:0] DEV_ADDR   = 8'h42,
    parameter int         RESET_WAIT = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        resend,
    output logic        advance,
    output logic        busy,
    output logic        config_done,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        START,
        SHIFT,
        STOP,
        GAP,
        DONE
    } state_t;

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(4 * CLK_DIV + RESET_WAIT + 1);

    localparam logic [QW-1:0] QMAX         = QW'(CLK_DIV - 1);
    localparam logic [DW-1:0] GAP_LAST     = DW'(4 * CLK_DIV - 1);
    localparam logic [DW-1:0] GAP_RST_LAST = DW'(4 * CLK_DIV + RESET_WAIT - 1);
    localparam logic [15:0]   COM7_RESET   = 16'h1280;

    state_t        state, state_nxt;
    logic [QW-1:0] qcnt, qcnt_nxt;        // clocks within the current quarter
    logic [1:0]    qidx, qidx_nxt;        // quarter index within a phase/slot
    logic [4:0]    bitcnt, bit_nxt;       // SHIFT slot 0..26
    logic [DW-1:0] dcnt, dcnt_nxt;        // FETCH wait and GAP/settle delay
    logic [26:0]   shreg, shreg_nxt;      // three bytes, each followed by an ACK slot
    logic          cmd_is_reset, is_rst_nxt;
    logic          resend_nxt, advance_nxt, busy_nxt, done_nxt;
    logic          sioc_nxt, siod_nxt, oe_nxt;
    logic          q_end;

    // Register state, counters and every output; reset returns the bus to idle-high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            qcnt         <= '0;
            qidx         <= '0;
            bitcnt       <= '0;
            dcnt         <= '0;
            shreg        <= '0;
            cmd_is_reset <= 1'b0;
            resend       <= 1'b0;
            advance      <= 1'b0;
            busy         <= 1'b0;
            config_done  <= 1'b0;
            sioc         <= 1'b1;
            siod_o       <= 1'b1;
            siod_oe      <= 1'b1;
        end else begin
            state        <= state_nxt;
            qcnt         <= qcnt_nxt;
            qidx         <= qidx_nxt;
            bitcnt       <= bit_nxt;
            dcnt         <= dcnt_nxt;
            shreg        <= shreg_nxt;
            cmd_is_reset <= is_rst_nxt;
            resend       <= resend_nxt;
            advance      <= advance_nxt;
            busy         <= busy_nxt;
            config_done  <= done_nxt;
            sioc         <= sioc_nxt;
            siod_o       <= siod_nxt;
            siod_oe      <= oe_nxt;
        end
    end

    // Next-state sequencing; pin levels are derived from the upcoming state so the
    // registered pins change exactly on quarter boundaries.
    always_comb begin
        state_nxt   = state;
        qcnt_nxt    = qcnt;
        qidx_nxt    = qidx;
        bit_nxt     = bitcnt;
        dcnt_nxt    = dcnt;
        shreg_nxt   = shreg;
        is_rst_nxt  = cmd_is_reset;
        resend_nxt  = 1'b0;
        advance_nxt = 1'b0;
        done_nxt    = config_done;
        q_end       = (qcnt == QMAX);

        unique case (state)
            IDLE: begin
                if (start) begin
                    resend_nxt = 1'b1;
                    done_nxt   = 1'b0;
                    dcnt_nxt   = '0;
                    state_nxt  = FETCH;
                end
            end
            FETCH: begin
                // ROM needs two clocks after resend/advance before its output is valid
                if (dcnt == DW'(1)) begin
                    dcnt_nxt  = '0;
                    state_nxt = CHECK;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            CHECK: begin
                if (finished) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    shreg_nxt  = {DEV_ADDR, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
                    is_rst_nxt = (command == COM7_RESET);
                    qcnt_nxt   = '0;
                    qidx_nxt   = '0;
                    state_nxt  = START;
                end
            end
            START: begin
                qcnt_nxt = q_end ? '0 : qcnt + 1'b1;
                if (q_end) begin
                    if (qidx == 2'd2) begin
                        qidx_nxt  = '0;
                        bit_nxt   = '0;
                        state_nxt = SHIFT;
                    end else begin
                        qidx_nxt = qidx + 2'd1;
                    end
                end
            end
            SHIFT: begin
                qcnt_nxt = q_end ? '0 : qcnt + 1'b1;
                if (q_end) begin
                    qidx_nxt = qidx + 2'd1;
                    if (qidx == 2'd3) begin
                        if (bitcnt == 5'd26) begin
                            bit_nxt   = '0;
                            state_nxt = STOP;
                        end else begin
                            bit_nxt = bitcnt + 5'd1;
                        end
                    end
                end
            end
            STOP: begin
                qcnt_nxt = q_end ? '0 : qcnt + 1'b1;
                if (q_end) begin
                    if (qidx == 2'd2) begin
                        qidx_nxt  = '0;
                        dcnt_nxt  = '0;
                        state_nxt = GAP;
                    end else begin
                        qidx_nxt = qidx + 2'd1;
                    end
                end
            end
            GAP: begin
                // 4Q idle, stretched by the sensor settle time after a soft reset
                if (dcnt == (cmd_is_reset ? GAP_RST_LAST : GAP_LAST)) begin
                    dcnt_nxt    = '0;
                    advance_nxt = 1'b1;
                    state_nxt   = FETCH;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = !((state_nxt == IDLE) || (state_nxt == DONE));

        sioc_nxt = 1'b1;
        siod_nxt = 1'b1;
        oe_nxt   = 1'b1;
        unique case (state_nxt)
            START: begin
                sioc_nxt = (qidx_nxt != 2'd2);
                siod_nxt = (qidx_nxt == 2'd0);
            end
            SHIFT: begin
                sioc_nxt = qidx_nxt[1];
                siod_nxt = shreg_nxt[5'd26 - bit_nxt];
                oe_nxt   = !((bit_nxt == 5'd8) || (bit_nxt == 5'd17) || (bit_nxt == 5'd26));
            end
            STOP: begin
                sioc_nxt = (qidx_nxt != 2'd0);
                siod_nxt = (qidx_nxt == 2'd2);
            end
            default: begin
                sioc_nxt = 1'b1;
                siod_nxt = 1'b1;
                oe_nxt   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ov7670_sccb_sender.sv
// Bench for ov7670_sccb_sender: behavioural register ROM, SCCB pin decoder and
// a scoreboard of expected {addr, reg, value} frames.
module tb_ov7670_sccb_sender;

    localparam int Q  = 4;
    localparam int RW = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] command;
    logic        finished;
    logic        resend, advance, busy, config_done;
    logic        sioc, siod_o, siod_oe;

    logic        rom_empty;
    logic [5:0]  rom_addr;

    int total = 0;
    int bad   = 0;

    ov7670_sccb_sender #(
        .CLK_DIV    (Q),
        .DEV_ADDR   (8'h42),
        .RESET_WAIT (RW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .command     (command),
        .finished    (finished),
        .resend      (resend),
        .advance     (advance),
        .busy        (busy),
        .config_done (config_done),
        .sioc        (sioc),
        .siod_o      (siod_o),
        .siod_oe     (siod_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [5:0] a);
        case (a)
            6'd0:  rom_word = 16'h1280;  6'd1:  rom_word = 16'h1280;
            6'd2:  rom_word = 16'h1204;  6'd3:  rom_word = 16'h1100;
            6'd4:  rom_word = 16'h0C00;  6'd5:  rom_word = 16'h3E00;
            6'd6:  rom_word = 16'h8C00;  6'd7:  rom_word = 16'h0400;
            6'd8:  rom_word = 16'h4010;  6'd9:  rom_word = 16'h3A04;
            6'd10: rom_word = 16'h1438;  6'd11: rom_word = 16'h4FB3;
            6'd12: rom_word = 16'h50B3;  6'd13: rom_word = 16'h5100;
            6'd14: rom_word = 16'h523D;  6'd15: rom_word = 16'h53A7;
            6'd16: rom_word = 16'h54E4;  6'd17: rom_word = 16'h589E;
            6'd18: rom_word = 16'h3DC0;  6'd19: rom_word = 16'h1714;
            6'd20: rom_word = 16'h1802;  6'd21: rom_word = 16'h3280;
            6'd22: rom_word = 16'h1903;  6'd23: rom_word = 16'h1A7B;
            6'd24: rom_word = 16'h030A;  6'd25: rom_word = 16'h0F41;
            default: rom_word = 16'hFFFF;
        endcase
    endfunction

    // Register ROM: address moves on the edge it sees resend/advance, data one edge later.
    always @(posedge clk) begin
        if (resend)       rom_addr <= 6'd0;
        else if (advance) rom_addr <= rom_addr + 6'd1;
        command  <= rom_word(rom_addr);
        finished <= rom_empty || (rom_word(rom_addr) == 16'hFFFF);
    end

    // scoreboard and monitor state
    logic [23:0] sb[$];
    int   cyc = 0;
    logic prev_sioc = 1'b1, prev_siod = 1'b1;
    logic in_frame = 1'b0, in_high = 1'b0, hi_val = 1'b0, have_stop = 1'b0;
    int   nbits = 0, t_rise = 0, t_stop = 0;
    logic bits [0:26];
    logic oes  [0:26];
    int   frames_started = 0, frames_done = 0;
    int   resend_cnt = 0, adv_cnt = 0, sioc_edges = 0;
    int   period_bad = 0, high_bad = 0, stable_bad = 0, periods = 0;
    int   sp [0:3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic end_frame();
        logic [23:0] got;
        logic        oe_ok;
        got   = '0;
        oe_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            got[23-k] = bits[k];
            got[15-k] = bits[9+k];
            got[7-k]  = bits[18+k];
        end
        for (int k = 0; k < 27; k++)
            if (oes[k] !== !((k == 8) || (k == 17) || (k == 26))) oe_ok = 1'b0;
        chk("frame_bits", nbits, 27);
        chk("frame_oe", oe_ok, 1);
        chk("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) chk("frame_data", got, sb.pop_front());
    endtask

    task automatic mon_step();
        if (!rst_n) begin
            in_frame  = 1'b0;
            in_high   = 1'b0;
            have_stop = 1'b0;
        end else begin
            if (resend)            resend_cnt++;
            if (advance)           adv_cnt++;
            if (sioc != prev_sioc) sioc_edges++;
            if (!in_frame) begin
                if (prev_sioc && sioc && prev_siod && !siod_o) begin
                    in_frame = 1'b1;
                    nbits    = 0;
                    frames_started++;
                    if (have_stop && frames_started >= 2 && frames_started <= 4)
                        sp[frames_started-1] = cyc - t_stop - 2 * Q;
                end
            end else if (!prev_sioc && sioc) begin
                if (nbits < 27) begin
                    bits[nbits] = siod_o;
                    oes[nbits]  = siod_oe;
                    if (nbits > 0) begin
                        periods++;
                        if (cyc - t_rise != 4 * Q) period_bad++;
                    end
                    hi_val  = siod_o;
                    in_high = 1'b1;
                    nbits++;
                end
                t_rise = cyc;
            end else if (prev_sioc && sioc) begin
                if (in_high) begin
                    if (siod_o != hi_val) stable_bad++;
                end else if (!prev_siod && siod_o) begin
                    in_frame  = 1'b0;
                    have_stop = 1'b1;
                    t_stop    = cyc;
                    frames_done++;
                    end_frame();
                end
            end else if (prev_sioc && !sioc) begin
                if (in_high) begin
                    if (cyc - t_rise != 2 * Q) high_bad++;
                    in_high = 1'b0;
                end
            end
        end
        prev_sioc = sioc;
        prev_siod = siod_o;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mon_step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_pass();
        for (int i = 0; i < 26; i++) sb.push_back({8'h42, rom_word(6'(i))});
    endtask

    task automatic wait_done(input int budget, output int busy_low);
        int n;
        n        = 0;
        busy_low = 0;
        while (!config_done && n < budget) begin
            tick();
            n++;
            if (!config_done && !busy) busy_low++;
        end
        chk("done_reached", config_done, 1);
    endtask

    initial begin
        int r0, a0, f0, fs0, e0, bl, n;
        rst_n     = 1'b0;
        start     = 1'b0;
        rom_empty = 1'b0;
        for (int i = 0; i < 4; i++) sp[i] = 0;
        repeat (3) tick();
        chk("rst_sioc", sioc, 1);
        chk("rst_siod", siod_o, 1);
        chk("rst_oe", siod_oe, 1);
        chk("rst_resend", resend, 0);
        chk("rst_advance", advance, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", config_done, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // full pass over the standard list
        r0 = resend_cnt; a0 = adv_cnt; f0 = frames_done;
        push_pass();
        pulse_start();
        chk("busy_on_start", busy, 1);
        repeat (3) tick();
        chk("resend_once", resend_cnt - r0, 1);
        wait_done(20000, bl);
        chk("busy_held", bl, 0);
        chk("busy_fell", busy, 0);
        chk("frames_pass1", frames_done - f0, 26);
        chk("adv_pass1", adv_cnt - a0, 26);
        chk("sb_drained1", sb.size(), 0);
        chk("gap_after_rst1", (sp[1] >= 4 * Q + RW + 3), 1);
        chk("gap_after_rst2", (sp[2] >= 4 * Q + RW + 3), 1);
        chk("gap_plain", sp[3], 4 * Q + 3);
        chk("sioc_periods_seen", periods, 26 * 26);
        chk("sioc_period", period_bad, 0);
        chk("sioc_duty", high_bad, 0);
        chk("siod_stable_high", stable_bad, 0);

        // empty list: finished at entry 0
        rom_empty = 1'b1;
        e0 = sioc_edges; fs0 = frames_started; a0 = adv_cnt;
        tick();
        pulse_start();
        chk("done_cleared", config_done, 0);
        n = 1;
        while (!config_done && n < 4) begin
            tick();
            n++;
        end
        chk("empty_done", config_done, 1);
        chk("empty_busy", busy, 0);
        chk("empty_sioc_quiet", sioc_edges - e0, 0);
        chk("empty_no_frames", frames_started - fs0, 0);
        chk("empty_no_adv", adv_cnt - a0, 0);
        rom_empty = 1'b0;
        repeat (2) tick();

        // reset in the middle of frame 5, start while busy ignored
        fs0 = frames_started;
        push_pass();
        pulse_start();
        n = 0;
        while (!((frames_started - fs0 >= 5) && in_frame && nbits >= 4) && n < 6000) begin
            tick();
            n++;
        end
        chk("reach_frame5", frames_started - fs0, 5);
        r0 = resend_cnt; a0 = adv_cnt;
        pulse_start();
        repeat (2) tick();
        chk("busy_start_resend", resend_cnt - r0, 0);
        chk("busy_start_adv", adv_cnt - a0, 0);
        chk("busy_still", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("midrst_sioc", sioc, 1);
        chk("midrst_siod", siod_o, 1);
        chk("midrst_oe", siod_oe, 1);
        chk("midrst_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        sb.delete();
        tick();

        // rerun from entry 0 after reset
        r0 = resend_cnt; a0 = adv_cnt; f0 = frames_done;
        push_pass();
        pulse_start();
        wait_done(20000, bl);
        chk("busy_held3", bl, 0);
        chk("resend_pass3", resend_cnt - r0, 1);
        chk("frames_pass3", frames_done - f0, 26);
        chk("adv_pass3", adv_cnt - a0, 26);
        chk("sb_drained3", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ov7670_sccb_sender.md
Name: ov7670_sccb_sender

Overview:
- Consumes the 16-bit {register, value} command stream from the OV7670 register-list ROM and writes each entry to the camera over SCCB as a 3-phase write.
- Drives the ROM's `resend`/`advance` inputs and stops on the ROM's `finished` flag (command 16'hFFFF).
- Sits between the register ROM and the camera SIOC/SIOD pins.
- Inserts a settle delay after any COM7 soft-reset command (16'h1280).

Parameters:
- CLK_DIV, 125: system clocks per SCCB quarter-bit (Q); bit period = 4*Q (50 MHz → 100 kHz).
- DEV_ADDR, 8'h42: SCCB write address, bit0 = 0.
- RESET_WAIT, 50000: clocks to wait after a 16'h1280 write before the next fetch (1 ms at 50 MHz).

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst_n, input, 1: synchronous reset, active-low.
- start, input, 1: single-cycle pulse; begins a full configuration pass.
- command, input, 16: ROM output {reg_addr[15:8], reg_data[7:0]}.
- finished, input, 1: ROM end-of-list flag.
- resend, output, 1: one-cycle pulse; rewinds ROM to entry 0.
- advance, output, 1: one-cycle pulse; steps ROM to next entry.
- busy, output, 1: high from accepted start until DONE.
- config_done, output, 1: high after a pass completes; cleared by the next accepted start.
- sioc, output, 1: SCCB clock.
- siod_o, output, 1: SCCB data value.
- siod_oe, output, 1: 1 = drive siod_o; 0 = release the pin.

Behaviour:
- Reset (rst_n = 0 at an edge) from any state: state=IDLE, sioc=1, siod_o=1, siod_oe=1, resend=0, advance=0, busy=0, config_done=0, all counters 0. A frame in flight is abandoned; the pins return to idle-high on that edge, with no stop condition generated.
- ROM latency: an address change takes effect at edge N, and `command`/`finished` are valid from edge N+1. The sender therefore waits exactly 2 clocks after a resend/advance pulse before sampling.
- States:
  - IDLE: bus idle-high. start=1 → assert resend for 1 cycle, set busy=1, clear config_done, go to FETCH.
  - FETCH: wait 2 clocks, then go to CHECK.
  - CHECK: finished=1 → DONE. Otherwise latch `command` into shift register {DEV_ADDR, command[15:8], command[7:0]} and go to START.
  - START: Q with sioc=1, siod_o=1; then Q with siod_o=0 (SDA falls, SCL high); then Q with sioc=0. Go to SHIFT.
  - SHIFT: 27 bit slots, 3 bytes × (8 data bits MSB-first + 1 don't-care bit).
    - Each slot lasts 4Q: Q0–Q1 sioc=0, Q2–Q3 sioc=1.
    - Data is updated only at the start of Q0, never while sioc=1.
    - Don't-care slots (9, 18, 27): siod_oe=0. All other slots: siod_oe=1.
    - The ACK value is not sampled or checked.
  - STOP: Q with sioc=0, siod_oe=1, siod_o=0; Q with sioc=1; Q with siod_o=1. Then go to GAP.
  - GAP: 4Q idle-high.
    - If the latched command = 16'h1280, wait a further RESET_WAIT clocks.
    - Then pulse advance for 1 cycle and go to FETCH.
  - DONE: busy=0, config_done=1 (held), go to IDLE.
- start while busy=1: ignored.
- start in IDLE with config_done=1: a new pass begins and config_done clears on the same edge.
- Bus stays high and driven in IDLE/DONE. sioc never toggles outside START/SHIFT/STOP.
- Counters:
  - Quarter counter: 0..CLK_DIV-1, wraps.
  - Bit counter: 0..26.
  - Delay counter: wide enough for RESET_WAIT.

Test Plan (CLK_DIV=4, RESET_WAIT=100, behavioural ROM with the standard 26-entry list):
- Reset, then start pulse → resend high for exactly 1 cycle; first frame on the pins decodes to bytes 0x42, 0x12, 0x80; siod_oe=0 during slots 9/18/27; start/stop edges occur with sioc=1.
- Full pass → exactly 26 frames and 26 advance pulses (the last advance makes finished=1); config_done rises and busy falls; busy was high for the whole pass.
- Frames 1 and 2 (16'h1280) → SCCB stop-to-next-start spacing ≥ 4Q+100+3 clocks; for frame 3 (16'h1204), spacing = 4Q+3 clocks with no reset wait.
- sioc period inside SHIFT measured = 16 clocks, 50% duty; siod_o stable throughout every sioc-high quarter.
- ROM returning finished=1 at entry 0 → no sioc toggles; config_done=1 within 4 cycles of start.
- rst_n low mid-SHIFT of frame 5 → next edge sioc=1, siod_o=1, siod_oe=1, busy=0. A start pulse during busy is ignored (advance count unchanged); a start after rst_n release reruns from entry 0.
